// File: rtl/traffic_light_control_if.sv
//------------------------------------------------------------------------------
// Module   : traffic_light_control_if
// Brief    : Sensor inputs, green indications and debug state for the
//            intersection controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface traffic_light_control_if;
  logic [1:0] l1l2;
  logic [1:0] y1y2;
  logic [1:0] state;

  modport master (
    output l1l2,
    input  y1y2,
    input  state
  );

  modport slave (
    input  l1l2,
    output y1y2,
    output state
  );
endinterface

`default_nettype wire

// File: rtl/traffic_light_control.sv
//------------------------------------------------------------------------------
// Module   : traffic_light_control
// Brief    : Moore FSM for a two-street intersection with min/max green and
//            fixed yellow dwell times.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module traffic_light_control #(
  parameter int MIN_GREEN     = 3,
  parameter int MAX_GREEN     = 8,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  traffic_light_control_if.slave  bus
);

  localparam int c_max_dwell = (MAX_GREEN > YELLOW_CYCLES) ? MAX_GREEN : YELLOW_CYCLES;
  localparam int c_tw        = (c_max_dwell > 1) ? $clog2(c_max_dwell) : 1;

  localparam logic [c_tw-1:0] c_min_last = c_tw'(MIN_GREEN - 1);
  localparam logic [c_tw-1:0] c_max_last = c_tw'(MAX_GREEN - 1);
  localparam logic [c_tw-1:0] c_yel_last = c_tw'(YELLOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [c_tw-1:0]   r_timer;
  logic [c_tw-1:0]   w_timer_next;
  logic [1:0]        w_y1y2;
  logic              w_green;
  logic              w_l1;
  logic              w_l2;

  assign w_l1 = bus.l1l2[1];
  assign w_l2 = bus.l1l2[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
      r_timer <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_y1y2       = 2'b00;
    w_green      = 1'b0;
    case (r_state)
      S0: begin
        w_y1y2  = 2'b10;
        w_green = 1'b1;
        if ((r_timer >= c_min_last) && (!w_l1 || (w_l2 && (r_timer >= c_max_last))))
          w_next_state = S1;
      end
      S1: begin
        if (r_timer == c_yel_last)
          w_next_state = S2;
      end
      S2: begin
        w_y1y2  = 2'b01;
        w_green = 1'b1;
        if ((r_timer >= c_min_last) && (!w_l2 || (w_l1 && (r_timer >= c_max_last))))
          w_next_state = S3;
      end
      S3: begin
        if (r_timer == c_yel_last)
          w_next_state = S0;
      end
      default: begin
        w_next_state = S0;
      end
    endcase
  end

  // Timer restarts on every state change; green saturation keeps a held street from wrapping.
  always_comb begin
    w_timer_next = r_timer + 1'b1;
    if (w_next_state != r_state)
      w_timer_next = '0;
    else if (w_green && (r_timer == c_max_last))
      w_timer_next = r_timer;
  end

  assign bus.y1y2  = w_y1y2;
  assign bus.state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_control.sv
//------------------------------------------------------------------------------
// Module   : tb_traffic_light_control
// Brief    : Directed self-checking bench for traffic_light_control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_traffic_light_control;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  traffic_light_control_if bus ();

  traffic_light_control #(
    .MIN_GREEN     (3),
    .MAX_GREEN     (8),
    .YELLOW_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_lights(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Leaves the bench just after a falling edge with reset released: first S0 cycle, timer 0.
  task automatic restart(input logic [1:0] sensors);
    reset    = 1'b0;
    bus.l1l2 = sensors;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.l1l2 = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bus.state !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_state[%0d] got %b exp 00", i, bus.state);
      end
      vectors++;
      if (bus.y1y2 !== 2'b10) begin
        miscompares++;
        $display("FAIL reset_lights[%0d] got %b exp 10", i, bus.y1y2);
      end
    end
  endtask

  task automatic test_no_traffic();
    logic [1:0] seq [10];
    seq = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    bus.l1l2 = 2'b00;
    reset    = 1'b1;
    for (int i = 0; i < 25; i++) begin
      vectors++;
      if (bus.state !== seq[i % 10]) begin
        miscompares++;
        $display("FAIL idle_state[%0d] got %b exp %b", i, bus.state, seq[i % 10]);
      end
      vectors++;
      if (bus.y1y2 !== exp_lights(seq[i % 10])) begin
        miscompares++;
        $display("FAIL idle_lights[%0d] got %b exp %b", i, bus.y1y2, exp_lights(seq[i % 10]));
      end
      @(negedge clk);
      #1;
    end
    // Now in the first S2 cycle of the third round; hit reset mid-cycle.
    vectors++;
    if (bus.state !== 2'b10) begin
      miscompares++;
      $display("FAIL pre_async_state got %b exp 10", bus.state);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset_state got %b exp 00", bus.state);
    end
    vectors++;
    if (bus.y1y2 !== 2'b10) begin
      miscompares++;
      $display("FAIL async_reset_lights got %b exp 10", bus.y1y2);
    end
  endtask

  task automatic test_both_busy();
    logic [1:0] exp;
    restart(2'b11);
    for (int i = 0; i < 24; i++) begin
      exp = (i < 8) ? 2'b00 : (i < 10) ? 2'b01 : (i < 18) ? 2'b10 : (i < 20) ? 2'b11 : 2'b00;
      vectors++;
      if (bus.state !== exp) begin
        miscompares++;
        $display("FAIL busy_state[%0d] got %b exp %b", i, bus.state, exp);
      end
      vectors++;
      if (bus.y1y2 !== exp_lights(exp)) begin
        miscompares++;
        $display("FAIL busy_lights[%0d] got %b exp %b", i, bus.y1y2, exp_lights(exp));
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_street1_only();
    logic [1:0] tail [4];
    tail = '{2'b01, 2'b01, 2'b10, 2'b10};
    restart(2'b10);
    for (int i = 0; i < 25; i++) begin
      vectors++;
      if (bus.state !== 2'b00 || bus.y1y2 !== 2'b10) begin
        miscompares++;
        $display("FAIL s1_hold[%0d] got state %b lights %b exp 00/10", i, bus.state, bus.y1y2);
      end
      @(negedge clk);
      #1;
    end
    bus.l1l2 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bus.state !== tail[i]) begin
        miscompares++;
        $display("FAIL s1_release[%0d] got %b exp %b", i, bus.state, tail[i]);
      end
    end
  endtask

  task automatic test_street2_only();
    logic [1:0] exp;
    restart(2'b01);
    for (int i = 0; i < 21; i++) begin
      exp = (i < 3) ? 2'b00 : (i < 5) ? 2'b01 : 2'b10;
      vectors++;
      if (bus.state !== exp) begin
        miscompares++;
        $display("FAIL s2_state[%0d] got %b exp %b", i, bus.state, exp);
      end
      vectors++;
      if (bus.y1y2 !== exp_lights(exp)) begin
        miscompares++;
        $display("FAIL s2_lights[%0d] got %b exp %b", i, bus.y1y2, exp_lights(exp));
      end
      @(negedge clk);
      #1;
    end
    // S2 timer is saturated at 7, so street 1 demand yields on the next edge.
    bus.l1l2 = 2'b11;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.state !== 2'b11) begin
      miscompares++;
      $display("FAIL s2_yield got %b exp 11", bus.state);
    end
  endtask

  task automatic test_yellow_immunity();
    logic [1:0] seq  [10];
    logic [1:0] stim [20];
    seq  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    stim = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11,
             2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
    restart(2'b00);
    for (int i = 0; i < 22; i++) begin
      vectors++;
      if (bus.state !== seq[i % 10]) begin
        miscompares++;
        $display("FAIL yel_state[%0d] got %b exp %b", i, bus.state, seq[i % 10]);
      end
      bus.l1l2 = (i < 20) ? stim[i] : 2'b00;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.l1l2    = 2'b00;
    test_reset();
    test_no_traffic();
    test_both_busy();
    test_street1_only();
    test_street2_only();
    test_yellow_immunity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_light_control.md
Name: traffic_light_control

Overview:
- Moore FSM controlling a two-street intersection: street 1 and street 2.
- Inputs are per-street vehicle sensors. Outputs are a per-street "go" (green) indication and the encoded current state for debug/visibility.
- Standalone leaf block clocked by the system clock; minimum/maximum green and yellow dwell times are set by parameters.

Parameters:
- MIN_GREEN, 3, minimum cycles a green state is held (must be ≥1).
- MAX_GREEN, 8, cycles after which a green street yields if the other street has traffic (must be ≥ MIN_GREEN).
- YELLOW_CYCLES, 2, exact cycles spent in each yellow state (must be ≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- l1l2  input  2  sensors. Bit 1 = l1, traffic waiting/present on street 1. Bit 0 = l2, same for street 2. Synchronous to clk.
- y1y2  output  2  light indication. Bit 1 = y1, street 1 green. Bit 0 = y2, street 2 green. 0 = not green (red or yellow).
- state  output  2  current FSM state encoding (registered).

Behaviour:
- One clock; reset is asynchronous and active-low.
- States (encoding on the state port):
  - S0 = 2'b00: street 1 green, street 2 red; y1y2 = 2'b10.
  - S1 = 2'b01: street 1 yellow, street 2 red; y1y2 = 2'b00.
  - S2 = 2'b10: street 2 green, street 1 red; y1y2 = 2'b01.
  - S3 = 2'b11: street 2 yellow, street 1 red; y1y2 = 2'b00.
- Moore outputs: y1y2 is decoded from the registered state only, with no combinational path from l1l2. y1y2 = 2'b11 is never produced.
- Dwell timer:
  - Internal counter, wide enough for max(MAX_GREEN, YELLOW_CYCLES)-1.
  - Cleared to 0 on every state change, so the first cycle in a state sees timer = 0.
  - Increments each cycle otherwise, saturating at MAX_GREEN-1 while in a green state.
- Transitions, evaluated at each rising clk edge:
  - S0 -> S1 when timer ≥ MIN_GREEN-1 AND (l1 = 0 OR (l2 = 1 AND timer ≥ MAX_GREEN-1)). Otherwise stay in S0.
  - S1 -> S2 when timer = YELLOW_CYCLES-1.
  - S2 -> S3 when timer ≥ MIN_GREEN-1 AND (l2 = 0 OR (l1 = 1 AND timer ≥ MAX_GREEN-1)). Otherwise stay in S2.
  - S3 -> S0 when timer = YELLOW_CYCLES-1.
- Consequences:
  - Green lasts at least MIN_GREEN cycles.
  - A green street with continuous traffic holds indefinitely if the other street is empty.
  - When both streets have traffic, each gets exactly MAX_GREEN cycles of green.
  - With no traffic anywhere, the lights cycle continuously (period 2*MIN_GREEN + 2*YELLOW_CYCLES).
  - Sensor changes during yellow are ignored.
- Reset:
  - reset = 0 immediately (asynchronously) forces state = S0, timer = 0, y1y2 = 2'b10, regardless of the current state.
  - While reset is held low, all outputs stay at the reset values.
  - Release is sampled by the next rising edge: the first cycle after release counts as timer = 0 in S0.
- No X propagation: l1l2 is treated as 0/1 only, and unused encodings do not exist (all 4 state codes are legal).

Test Plan:
- Reset: hold reset = 0 for 6 cycles with l1l2 = 00 -> state = 00 and y1y2 = 10 throughout. Assert reset low mid-cycle while in S2 -> state = 00 and y1y2 = 10 before the next clk edge.
- No traffic: release reset with l1l2 = 00 -> sequence S0 ×3, S1 ×2, S2 ×3, S3 ×2, repeating; y1y2 = 10, 00, 01, 00 accordingly.
- Both busy: l1l2 = 11 from S0 entry -> S0 for 8 cycles, S1 ×2, S2 for 8 cycles, S3 ×2, then back to S0.
- Street 1 only: l1l2 = 10 applied in S0 -> stays S0 with y1y2 = 10 indefinitely (check ≥20 cycles; timer saturates without wrap). Then change to 00 after 20 cycles -> S1 on the next edge.
- Street 2 only: l1l2 = 01 from reset release -> S0 ×3, S1 ×2, then S2 held with y1y2 = 01 indefinitely. Then change to 11 -> S3 once S2's timer reaches 7 (8 cycles of S2 total).
- Yellow immunity: toggle l1l2 every cycle during S1/S3 -> yellow duration is exactly 2 cycles, and the following state is unaffected.
